minion_sprite_renderer: RTL and testbench



---
 rtl/minion_sprite_renderer.sv | 140 ++++++++++++++
 tb/tb_minion_sprite_renderer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/minion_sprite_renderer.sv
// rtl/minion_sprite_renderer.sv - sprite ROM addressing, palette lookup, flip and post-hit blink
// Two-stage pixel pipeline: stage 1 drives the ROM address, stage 2 maps the returned index to RGB.
module minion_sprite_renderer #(
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 53,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_PERIOD = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        flip,
  input  logic        hit,
  output logic [18:0] read_address,
  input  logic [2:0]  yellow_in,
  output logic        sprite_on,
  output logic [23:0] pixel_rgb,
  output logic        blinking
);

  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int PW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  typedef enum logic {NORMAL = 1'b0, BLINK = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frames_left_q, frames_left_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic          visible_q, visible_d;
  logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic          flip_q, flip_d;
  logic [18:0]   read_address_q, read_address_d;
  logic          in_box_q, in_box_d;
  logic          sprite_on_q, sprite_on_d;
  logic [23:0]   pixel_rgb_q, pixel_rgb_d;

  logic [10:0]   dx, dy, col;
  logic          in_box;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 24'hFFD800;
      3'd2:    palette = 24'h000000;
      3'd3:    palette = 24'hFFFFFF;
      3'd4:    palette = 24'h1E5AC8;
      3'd5:    palette = 24'h808080;
      3'd6:    palette = 24'h6B3E1E;
      3'd7:    palette = 24'hE01010;
      default: palette = 24'h000000;
    endcase
  endfunction

  // Position and flip only move at frame_start so a frame never tears.
  always_comb begin
    pos_x_d = frame_start ? sprite_x : pos_x_q;
    pos_y_d = frame_start ? sprite_y : pos_y_q;
    flip_d  = frame_start ? flip     : flip_q;
  end

  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, pos_x_q};
    dy     = {1'b0, DrawY} - {1'b0, pos_y_q};
    in_box = ({1'b0, DrawX} >= {1'b0, pos_x_q}) &&
             ({1'b0, DrawX} <  ({1'b0, pos_x_q} + 11'(SPRITE_W))) &&
             ({1'b0, DrawY} >= {1'b0, pos_y_q}) &&
             ({1'b0, DrawY} <  ({1'b0, pos_y_q} + 11'(SPRITE_H)));
    col    = flip_q ? (11'(SPRITE_W - 1) - dx) : dx;
    read_address_d = in_box ? (({8'b0, dy} * 19'(SPRITE_W)) + {8'b0, col}) : 19'd0;
    in_box_d       = in_box;
    sprite_on_d    = in_box_q && (yellow_in != 3'd0) && visible_q;
    pixel_rgb_d    = sprite_on_d ? palette(yellow_in) : 24'h000000;
  end

  // A hit always wins over a coincident frame_start: restart, no decrement.
  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    phase_cnt_d   = phase_cnt_q;
    visible_d     = visible_q;
    if (hit) begin
      state_d       = BLINK;
      frames_left_d = FW'(BLINK_FRAMES);
      phase_cnt_d   = '0;
      visible_d     = 1'b0;
    end else if (frame_start && state_q == BLINK) begin
      if (frames_left_q <= FW'(1)) begin
        state_d       = NORMAL;
        frames_left_d = '0;
        phase_cnt_d   = '0;
        visible_d     = 1'b1;
      end else begin
        frames_left_d = frames_left_q - FW'(1);
        if (phase_cnt_q == PW'(BLINK_PERIOD - 1)) begin
          phase_cnt_d = '0;
          visible_d   = ~visible_q;
        end else begin
          phase_cnt_d = phase_cnt_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q        <= NORMAL;
      frames_left_q  <= '0;
      phase_cnt_q    <= '0;
      visible_q      <= 1'b1;
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      flip_q         <= 1'b0;
      read_address_q <= '0;
      in_box_q       <= 1'b0;
      sprite_on_q    <= 1'b0;
      pixel_rgb_q    <= '0;
    end else begin
      state_q        <= state_d;
      frames_left_q  <= frames_left_d;
      phase_cnt_q    <= phase_cnt_d;
      visible_q      <= visible_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      flip_q         <= flip_d;
      read_address_q <= read_address_d;
      in_box_q       <= in_box_d;
      sprite_on_q    <= sprite_on_d;
      pixel_rgb_q    <= pixel_rgb_d;
    end
  end

  assign read_address = read_address_q;
  assign sprite_on    = sprite_on_q;
  assign pixel_rgb    = pixel_rgb_q;
  assign blinking     = (state_q == BLINK);

endmodule

// File: tb/tb_minion_sprite_renderer.sv
// tb/tb_minion_sprite_renderer.sv - directed self-checking bench for minion_sprite_renderer
module tb_minion_sprite_renderer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic        flip, hit;
  logic [18:0] read_address;
  logic [2:0]  yellow_in;
  logic        sprite_on;
  logic [23:0] pixel_rgb;
  logic        blinking;

  int total = 0;
  int bad   = 0;

  minion_sprite_renderer #(
    .SPRITE_W(32), .SPRITE_H(53), .BLINK_FRAMES(6), .BLINK_PERIOD(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .flip(flip), .hit(hit), .read_address(read_address), .yellow_in(yellow_in),
    .sprite_on(sprite_on), .pixel_rgb(pixel_rgb), .blinking(blinking)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; hit = 1'b0; flip = 1'b0;
    DrawX = 10'd5; DrawY = 10'd5; sprite_x = 10'd0; sprite_y = 10'd0; yellow_in = 3'd1;
    step(); step(); step();
    chk("rst_addr", 32'(read_address), 32'd0);
    chk("rst_on",   32'(sprite_on),    32'd0);
    chk("rst_rgb",  32'(pixel_rgb),    32'd0);
    chk("rst_blink",32'(blinking),     32'd0);
    Reset_n = 1'b1;

    sprite_x = 10'd100; sprite_y = 10'd50; flip = 1'b0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    DrawX = 10'd105; DrawY = 10'd52; yellow_in = 3'd1;
    step();
    chk("addr_noflip", 32'(read_address), 32'd69);
    step();
    chk("on_noflip",  32'(sprite_on), 32'd1);
    chk("rgb_noflip", 32'(pixel_rgb), 32'hFFD800);

    flip = 1'b1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    DrawX = 10'd100; DrawY = 10'd50;
    step();
    chk("addr_flip_tl", 32'(read_address), 32'd31);
    DrawX = 10'd132;
    step();
    chk("addr_outside", 32'(read_address), 32'd0);
    step();
    chk("on_outside", 32'(sprite_on), 32'd0);
    DrawX = 10'd131; DrawY = 10'd102;
    step();
    chk("addr_flip_br", 32'(read_address), 32'd1664);
    DrawY = 10'd103;
    step();
    chk("addr_below", 32'(read_address), 32'd0);
    DrawY = 10'd102;
    step();

    yellow_in = 3'd0;
    step();
    chk("on_transp",  32'(sprite_on), 32'd0);
    chk("rgb_transp", 32'(pixel_rgb), 32'h000000);
    yellow_in = 3'd7;
    step();
    chk("on_idx7",  32'(sprite_on), 32'd1);
    chk("rgb_idx7", 32'(pixel_rgb), 32'hE01010);

    sprite_x = 10'd300; flip = 1'b0;
    DrawX = 10'd105; DrawY = 10'd52;
    step();
    chk("addr_notear", 32'(read_address), 32'd90);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    DrawX = 10'd305;
    step();
    chk("addr_newpos", 32'(read_address), 32'd69);
    DrawX = 10'd105;
    step();
    chk("addr_oldpos", 32'(read_address), 32'd0);

    DrawX = 10'd305; yellow_in = 3'd1;
    step(); step();
    chk("on_pre_hit", 32'(sprite_on), 32'd1);
    hit = 1'b1; step(); hit = 1'b0;
    chk("blink_hit", 32'(blinking), 32'd1);
    step();
    chk("on_after_hit", 32'(sprite_on), 32'd0);
    frame(); chk("f1_on", 32'(sprite_on), 32'd0); chk("f1_bl", 32'(blinking), 32'd1);
    frame(); chk("f2_on", 32'(sprite_on), 32'd1); chk("f2_bl", 32'(blinking), 32'd1);
    frame(); chk("f3_on", 32'(sprite_on), 32'd1); chk("f3_bl", 32'(blinking), 32'd1);
    frame(); chk("f4_on", 32'(sprite_on), 32'd0); chk("f4_bl", 32'(blinking), 32'd1);
    frame(); chk("f5_on", 32'(sprite_on), 32'd0); chk("f5_bl", 32'(blinking), 32'd1);
    frame(); chk("f6_on", 32'(sprite_on), 32'd1); chk("f6_bl", 32'(blinking), 32'd0);

    hit = 1'b1; step(); hit = 1'b0;
    frame(); frame(); frame();
    hit = 1'b1; step(); hit = 1'b0; step();
    chk("rehit_on", 32'(sprite_on), 32'd0);
    for (int i = 0; i < 5; i++) frame();
    chk("rehit_f5_bl", 32'(blinking), 32'd1);
    frame();
    chk("rehit_f6_bl", 32'(blinking), 32'd0);
    chk("rehit_f6_on", 32'(sprite_on), 32'd1);

    hit = 1'b1; frame_start = 1'b1; step(); hit = 1'b0; frame_start = 1'b0; step();
    chk("coin_on", 32'(sprite_on), 32'd0);
    for (int i = 0; i < 5; i++) frame();
    chk("coin_f5_bl", 32'(blinking), 32'd1);
    frame();
    chk("coin_f6_bl", 32'(blinking), 32'd0);

    hit = 1'b1; step(); hit = 1'b0;
    Reset_n = 1'b0; step();
    chk("midrst_bl",   32'(blinking),     32'd0);
    chk("midrst_on",   32'(sprite_on),    32'd0);
    chk("midrst_addr", 32'(read_address), 32'd0);
    chk("midrst_rgb",  32'(pixel_rgb),    32'd0);
    Reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
